butterfly_pipe_unit: RTL

Pipelined, parametrised radix-2 complex butterfly for the FFT datapath. It computes either a decimation-in-time (DIT) or a decimation-in-frequency (DIF) butterfly, selected per transaction, on signed fixed-point complex operands. Each result can optionally be scaled by 1/2, and overflow either wraps or saturates. The block sits between the stage-data buffer and twiddle ROM on the input side and the next FFT stage on the output side, using val/rdy handshakes on both sides. It sustains one butterfly per cycle.

---
 rtl/butterfly_pipe_unit.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/butterfly_pipe_unit.sv
// butterfly_pipe_unit: three-stage elastic radix-2 complex butterfly (DIT or DIF per
// transaction) on signed fixed-point operands with optional 1/2 scaling and wrap or
// saturate narrowing.
//
// Ports:
//   clk_i, reset_i            clock, asynchronous active-high reset
//   recv_val_i / recv_rdy_o   input handshake
//   mode_dif_i, scale_i       per-transaction DIF select and 1/2 scaling
//   ar_i, ac_i, br_i, bc_i    operands a, b (real, imag)
//   wr_i, wc_i                twiddle w (real, imag)
//   send_val_o / send_rdy_i   output handshake
//   cr_o, cc_o, dr_o, dc_o    registered results c, d (real, imag)
module butterfly_pipe_unit #(
  parameter int unsigned N   = 32,
  parameter int unsigned D   = 16,
  parameter bit          SAT = 1'b0
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         recv_val_i,
  output logic         recv_rdy_o,
  input  logic         mode_dif_i,
  input  logic         scale_i,
  input  logic [N-1:0] ar_i,
  input  logic [N-1:0] ac_i,
  input  logic [N-1:0] br_i,
  input  logic [N-1:0] bc_i,
  input  logic [N-1:0] wr_i,
  input  logic [N-1:0] wc_i,
  output logic         send_val_o,
  input  logic         send_rdy_i,
  output logic [N-1:0] cr_o,
  output logic [N-1:0] cc_o,
  output logic [N-1:0] dr_o,
  output logic [N-1:0] dc_o
);

  localparam int unsigned W1 = N + 1;
  localparam int unsigned W2 = N + 2;
  localparam int unsigned W3 = N + 3;
  localparam int unsigned PW = 2 * N + 2;  // holds ur*wr +/- uc*wc without loss

  localparam logic signed [W3-1:0] MaxV = {4'b0000, {(N-1){1'b1}}};
  localparam logic signed [W3-1:0] MinV = {4'b1111, {(N-1){1'b0}}};

  function automatic logic [N-1:0] narrow(logic signed [W3-1:0] x);
    logic [N-1:0] r;
    r = x[N-1:0];
    if (SAT) begin
      if (x > MaxV)      r = {1'b0, {(N-1){1'b1}}};
      else if (x < MinV) r = {1'b1, {(N-1){1'b0}}};
    end
    return r;
  endfunction

  // ---------------------------------------------------------------- flow control
  logic en1, en2, en3;
  logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;

  // A stage may load when it is empty or its content is moving on this edge.
  always_comb begin
    en3  = !v3_q || send_rdy_i;
    en2  = !v2_q || en3;
    en1  = !v1_q || en2;
    v1_d = en1 ? recv_val_i : v1_q;
    v2_d = en2 ? v1_q : v2_q;
    v3_d = en3 ? v2_q : v3_q;
  end

  assign recv_rdy_o = en1;
  assign send_val_o = v3_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      v3_q <= v3_d;
    end
  end

  // ---------------------------------------------------------------- S1: pre-add
  logic [W1-1:0] a_r_x, a_c_x, b_r_x, b_c_x;
  logic [W1-1:0] s1_r_d, s1_c_d, u1_r_d, u1_c_d;
  logic [W1-1:0] s1_r_q, s1_c_q, u1_r_q, u1_c_q;
  logic [N-1:0]  w1_r_q, w1_c_q;
  logic          dif1_q, scl1_q;

  always_comb begin
    a_r_x  = {ar_i[N-1], ar_i};
    a_c_x  = {ac_i[N-1], ac_i};
    b_r_x  = {br_i[N-1], br_i};
    b_c_x  = {bc_i[N-1], bc_i};
    s1_r_d = mode_dif_i ? a_r_x + b_r_x : a_r_x;
    s1_c_d = mode_dif_i ? a_c_x + b_c_x : a_c_x;
    u1_r_d = mode_dif_i ? a_r_x - b_r_x : b_r_x;
    u1_c_d = mode_dif_i ? a_c_x - b_c_x : b_c_x;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      s1_r_q <= '0;
      s1_c_q <= '0;
      u1_r_q <= '0;
      u1_c_q <= '0;
      w1_r_q <= '0;
      w1_c_q <= '0;
      dif1_q <= 1'b0;
      scl1_q <= 1'b0;
    end else if (en1 && recv_val_i) begin
      s1_r_q <= s1_r_d;
      s1_c_q <= s1_c_d;
      u1_r_q <= u1_r_d;
      u1_c_q <= u1_c_d;
      w1_r_q <= wr_i;
      w1_c_q <= wc_i;
      dif1_q <= mode_dif_i;
      scl1_q <= scale_i;
    end
  end

  // ---------------------------------------------------------------- S2: multiply
  logic signed [PW-1:0] u_r_x, u_c_x, w_r_x, w_c_x, pr_full, pc_full;
  logic [W2-1:0]        p2_r_d, p2_c_d, p2_r_q, p2_c_q;
  logic [W1-1:0]        s2_r_q, s2_c_q;
  logic                 dif2_q, scl2_q;

  always_comb begin
    u_r_x   = {{(PW-W1){u1_r_q[W1-1]}}, u1_r_q};
    u_c_x   = {{(PW-W1){u1_c_q[W1-1]}}, u1_c_q};
    w_r_x   = {{(PW-N){w1_r_q[N-1]}}, w1_r_q};
    w_c_x   = {{(PW-N){w1_c_q[N-1]}}, w1_c_q};
    pr_full = u_r_x * w_r_x - u_c_x * w_c_x;
    pc_full = u_r_x * w_c_x + u_c_x * w_r_x;
    // Floor the fractional product back to Q(d), keep the low n+2 bits.
    p2_r_d  = W2'(pr_full >>> D);
    p2_c_d  = W2'(pc_full >>> D);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      p2_r_q <= '0;
      p2_c_q <= '0;
      s2_r_q <= '0;
      s2_c_q <= '0;
      dif2_q <= 1'b0;
      scl2_q <= 1'b0;
    end else if (en2 && v1_q) begin
      p2_r_q <= p2_r_d;
      p2_c_q <= p2_c_d;
      s2_r_q <= s1_r_q;
      s2_c_q <= s1_c_q;
      dif2_q <= dif1_q;
      scl2_q <= scl1_q;
    end
  end

  // ---------------------------------------------------------------- S3: post-add, output
  logic signed [W3-1:0] s_r_x, s_c_x, p_r_x, p_c_x;
  logic signed [W3-1:0] c_r_w, c_c_w, d_r_w, d_c_w;
  logic [N-1:0]         cr_d, cc_d, dr_d, dc_d;
  logic [N-1:0]         cr_q, cc_q, dr_q, dc_q;

  always_comb begin
    s_r_x = {{2{s2_r_q[W1-1]}}, s2_r_q};
    s_c_x = {{2{s2_c_q[W1-1]}}, s2_c_q};
    p_r_x = {p2_r_q[W2-1], p2_r_q};
    p_c_x = {p2_c_q[W2-1], p2_c_q};
    c_r_w = dif2_q ? s_r_x : s_r_x + p_r_x;
    c_c_w = dif2_q ? s_c_x : s_c_x + p_c_x;
    d_r_w = dif2_q ? p_r_x : s_r_x - p_r_x;
    d_c_w = dif2_q ? p_c_x : s_c_x - p_c_x;
    if (scl2_q) begin
      c_r_w = c_r_w >>> 1;
      c_c_w = c_c_w >>> 1;
      d_r_w = d_r_w >>> 1;
      d_c_w = d_c_w >>> 1;
    end
    cr_d = narrow(c_r_w);
    cc_d = narrow(c_c_w);
    dr_d = narrow(d_r_w);
    dc_d = narrow(d_c_w);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cr_q <= '0;
      cc_q <= '0;
      dr_q <= '0;
      dc_q <= '0;
    end else if (en3 && v2_q) begin
      cr_q <= cr_d;
      cc_q <= cc_d;
      dr_q <= dr_d;
      dc_q <= dc_d;
    end
  end

  assign cr_o = cr_q;
  assign cc_o = cc_q;
  assign dr_o = dr_q;
  assign dc_o = dc_q;

endmodule
